// File: rtl/write_operation_ctrl.sv
// Write side of the 8 x 64-bit register file: a 2-entry request FIFO feeding
// one register commit per cycle, with clear, hold and a wrapping commit counter.
module write_operation_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_hold,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] to_reg0,
    output logic [DATA_WIDTH-1:0] to_reg1,
    output logic [DATA_WIDTH-1:0] to_reg2,
    output logic [DATA_WIDTH-1:0] to_reg3,
    output logic [DATA_WIDTH-1:0] to_reg4,
    output logic [DATA_WIDTH-1:0] to_reg5,
    output logic [DATA_WIDTH-1:0] to_reg6,
    output logic [DATA_WIDTH-1:0] to_reg7,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  commit_cnt
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    // FIFO occupancy doubles as the controller state
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  push, pop;
    logic                  wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] fifo_addr [2];
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [DATA_WIDTH-1:0] regs      [NREG];

    // Handshake, pop decision and occupancy transitions
    always_comb begin
        state_nxt = state;
        wr_ready  = (state != FULL);
        push      = wr_valid & (state != FULL);
        // clr forces the head out so it can be dropped alongside the clear
        pop       = (state != EMPTY) & (~wr_hold | clr);
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL:    if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Circular pointers into the two FIFO slots
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // FIFO payload storage; validity is tracked by the state alone
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    // Register file: clear wins over a commit in the same cycle
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (pop) begin
            regs[fifo_addr[rd_ptr]] <= fifo_data[rd_ptr];
        end
    end

    // Commit counter skips entries dropped by clr
    always_ff @(posedge clk) begin
        if (reset)            commit_cnt <= '0;
        else if (pop && !clr) commit_cnt <= commit_cnt + 1'b1;
    end

    assign busy    = (state != EMPTY);
    assign to_reg0 = regs[0];
    assign to_reg1 = regs[1];
    assign to_reg2 = regs[2];
    assign to_reg3 = regs[3];
    assign to_reg4 = regs[4];
    assign to_reg5 = regs[5];
    assign to_reg6 = regs[6];
    assign to_reg7 = regs[7];

endmodule

// File: tb/tb_write_operation_ctrl.sv
// Bench for write_operation_ctrl: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_write_operation_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_hold;
    logic        clr;
    logic [63:0] to_reg [8];
    logic        busy;
    logic [7:0]  commit_cnt;

    int tests = 0;
    int fails = 0;

    write_operation_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_hold(wr_hold), .clr(clr),
        .to_reg0(to_reg[0]), .to_reg1(to_reg[1]), .to_reg2(to_reg[2]), .to_reg3(to_reg[3]),
        .to_reg4(to_reg[4]), .to_reg5(to_reg[5]), .to_reg6(to_reg[6]), .to_reg7(to_reg[7]),
        .busy(busy), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending requests as an ordered queue
    typedef struct packed {
        logic [2:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_reg [8];
    int          m_cnt;
    bit          model_on = 0;

    always @(posedge clk) begin
        bit   do_pop, do_push;
        ent_t h;
        if (reset) begin
            q.delete();
            for (int i = 0; i < 8; i++) m_reg[i] = 64'd0;
            m_cnt    = 0;
            model_on = 1;
        end else begin
            do_pop  = (q.size() > 0) && (!wr_hold || clr);
            do_push = wr_valid && (q.size() < 2);
            if (do_pop) begin
                h = q.pop_front();
                if (!clr) begin
                    m_reg[h.a] = h.d;
                    m_cnt      = (m_cnt + 1) % 256;
                end
            end
            if (clr) for (int i = 0; i < 8; i++) m_reg[i] = 64'd0;
            if (do_push) q.push_back('{a: wr_addr, d: wr_data});
        end
    end

    // Every-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (model_on) begin
            chk("wr_ready", {63'd0, wr_ready}, {63'd0, q.size() < 2});
            chk("busy", {63'd0, busy}, {63'd0, q.size() > 0});
            chk("commit_cnt", {56'd0, commit_cnt}, 64'(m_cnt));
            for (int i = 0; i < 8; i++) chk($sformatf("to_reg%0d", i), to_reg[i], m_reg[i]);
        end
    end

    // One clock edge with the given inputs, returning at the following falling edge
    task automatic cyc(input logic v, input logic [2:0] a, input logic [63:0] d,
                       input logic h, input logic c);
        wr_valid = v; wr_addr = a; wr_data = d; wr_hold = h; clr = c;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        wr_valid = 0; wr_addr = 0; wr_data = 0; wr_hold = 0; clr = 0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_cnt", {56'd0, commit_cnt}, 64'd0);
        chk("reset_ready", {63'd0, wr_ready}, 64'd1);
        reset = 1'b0;

        // 1: single write, visible one edge after acceptance
        cyc(1, 3, 64'h78, 0, 0);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_reg3_early", to_reg[3], 64'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t1_reg3", to_reg[3], 64'h78);
        chk("t1_cnt", {56'd0, commit_cnt}, 64'd1);

        // 2: fill under hold, keep it held a cycle, then drain in order
        cyc(1, 0, 64'd5, 1, 0);
        cyc(1, 1, 64'd6, 1, 0);
        chk("t2_ready", {63'd0, wr_ready}, 64'd0);
        chk("t2_busy", {63'd0, busy}, 64'd1);
        cyc(0, 0, 0, 1, 0);
        chk("t2_ready_held", {63'd0, wr_ready}, 64'd0);
        chk("t2_reg0_held", to_reg[0], 64'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_reg0", to_reg[0], 64'd5);
        chk("t2_reg1_early", to_reg[1], 64'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_reg1", to_reg[1], 64'd6);
        chk("t2_cnt", {56'd0, commit_cnt}, 64'd3);

        // 3: back-to-back writes to one address, later value wins
        cyc(1, 7, 64'd1, 0, 0);
        cyc(1, 7, 64'd2, 0, 0);
        cyc(1, 7, 64'd6, 0, 0);
        cyc(1, 7, 64'd24, 0, 0);
        chk("t3_ready", {63'd0, wr_ready}, 64'd1);
        cyc(0, 0, 0, 0, 0);
        chk("t3_reg7", to_reg[7], 64'd24);
        chk("t3_cnt", {56'd0, commit_cnt}, 64'd7);

        // 4: load all registers, then clr on the pop cycle of a fresh write
        for (int i = 0; i < 8; i++) cyc(1, 3'(i), 64'hFF, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_reg5_ff", to_reg[5], 64'hFF);
        chk("t4_cnt_load", {56'd0, commit_cnt}, 64'd15);
        cyc(1, 2, 64'h10, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t4_reg2", to_reg[2], 64'd0);
        chk("t4_reg0", to_reg[0], 64'd0);
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk("t4_cnt", {56'd0, commit_cnt}, 64'd15);

        // 5: reset while full under hold discards everything
        cyc(1, 4, 64'hABCD, 1, 0);
        cyc(1, 6, 64'h1234, 1, 0);
        chk("t5_full", {63'd0, wr_ready}, 64'd0);
        reset = 1'b1;
        cyc(0, 0, 0, 1, 0);
        reset = 1'b0;
        chk("t5_ready", {63'd0, wr_ready}, 64'd1);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_cnt", {56'd0, commit_cnt}, 64'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t5_reg4", to_reg[4], 64'd0);
        chk("t5_reg6", to_reg[6], 64'd0);

        // 6: 256 commits wrap the counter
        for (int i = 0; i < 256; i++) cyc(1, 1, 64'(i), 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_cnt_wrap", {56'd0, commit_cnt}, 64'd0);
        chk("t6_reg1", to_reg[1], 64'd255);

        cyc(0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
